multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15: maximum cycles spent waiting for mem_ready in one memory state before trapping; legal range 1..255.
REQ-002 Parameter ALUOP_W, default 2: width of alu_op.
REQ-003 Port clk, input, 1: single clock; all state changes on the rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port opcode, input, 6: instruction opcode field, driven from the instruction register.
REQ-006 Port mem_ready, input, 1: memory has completed the current read or write this cycle.
REQ-007 Outputs, 1 bit each: pc_write, pc_write_cond, beq_sel, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_write, reg_dst, alu_src_a.
REQ-008 Outputs alu_src_b (2 bits), pc_source (2 bits), alu_op (ALUOP_W bits).
REQ-009 Output illegal_op, 1: one-cycle pulse on decode of an unsupported opcode.
REQ-010 Output mem_timeout, 1: sticky flag; set when a memory wait times out.
REQ-011 Output state, 4: current FSM state, for debug.

Function
REQ-012 The block SHALL be a Moore FSM with states FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WB, MEM_WR, R_EX, R_WB, BRANCH, JUMP, IMM_EX, IMM_WB and TRAP.
REQ-013 Outputs not listed for a state SHALL be 0 in that state.
REQ-014 FETCH SHALL drive mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01 and alu_op=00.
REQ-015 In FETCH, ir_write and pc_write SHALL be 1 only in the cycle mem_ready=1; that cycle the FSM SHALL move to DECODE, otherwise it stays in FETCH.
REQ-016 DECODE SHALL drive alu_src_a=0, alu_src_b=11 and alu_op=00, and latch opcode into an internal register used by all later states.
REQ-017 DECODE next state: lw(23h)/sw(2Bh)->MEM_ADR; R-type(00h)->R_EX; beq(04h)/bne(05h)->BRANCH; j(02h)->JUMP; addi(08h)/andi(0Ch)->IMM_EX; any other opcode->FETCH with illegal_op=1 for that cycle.
REQ-018 MEM_ADR SHALL drive alu_src_a=1, alu_src_b=10 and alu_op=00, then go to MEM_RD for lw or MEM_WR for sw.
REQ-019 MEM_RD SHALL drive i_or_d=1 and mem_read=1 until mem_ready, then go to MEM_WB.
REQ-020 MEM_WB SHALL drive mem_to_reg=1, reg_dst=0 and reg_write=1, then go to FETCH.
REQ-021 MEM_WR SHALL drive i_or_d=1 and mem_write=1 until mem_ready, then go to FETCH.
REQ-022 R_EX SHALL drive alu_src_a=1, alu_src_b=00 and alu_op=10, then go to R_WB; R_WB SHALL drive reg_dst=1 and reg_write=1, then go to FETCH.
REQ-023 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1 and pc_source=01, with beq_sel=1 for beq and 0 for bne, then go to FETCH.
REQ-024 JUMP SHALL drive pc_write=1 and pc_source=10, then go to FETCH.
REQ-025 IMM_EX SHALL drive alu_src_a=1, alu_src_b=10, and alu_op=00 for addi or 11 for andi, then go to IMM_WB.
REQ-026 IMM_WB SHALL drive reg_dst=0, mem_to_reg=0 and reg_write=1, then go to FETCH.
REQ-027 An 8-bit wait counter SHALL clear on entry to FETCH, MEM_RD or MEM_WR and increment each cycle spent there with mem_ready=0.
REQ-028 If the wait counter equals MEM_TIMEOUT while mem_ready=0, the FSM SHALL enter TRAP and set mem_timeout the next cycle.
REQ-029 If mem_ready=1 arrives in the same cycle the counter equals MEM_TIMEOUT, the access completes normally and no trap occurs.
REQ-030 TRAP SHALL drive all enables 0 and SHALL be left only by reset.
REQ-031 With zero-wait memory, instruction lengths SHALL be: lw 5, sw 4, R-type 4, addi/andi 4, beq/bne 3, j 3 cycles.

Reset
REQ-032 Asserting rst SHALL immediately force state=FETCH, clear the wait counter, the latched opcode and mem_timeout, and deassert illegal_op.
REQ-033 Reset asserted mid-instruction, including during TRAP, SHALL abandon the instruction; the first rising edge after deassertion evaluates FETCH.

Structure
REQ-034 State encodings (FETCH=0 through TRAP=12), the opcode constants and the alu_op, alu_src_b and pc_source codes SHALL live in a shared package, cpu_ctrl_pkg.
REQ-035 The wait counter SHALL be a separate sub-module, mem_wait_timer, with inputs clk, rst, clear and waiting and output expired.

Verification
REQ-036 opcode=23h with mem_ready held at 1 -> state sequence 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 in state 4 only.
REQ-037 opcode=05h -> BRANCH with pc_write_cond=1, beq_sel=0 and pc_source=01; opcode=04h -> beq_sel=1.
REQ-038 opcode=2Bh with mem_ready low for 3 cycles in MEM_WR -> mem_write=1 for 4 cycles, then FETCH; mem_timeout stays 0.
REQ-039 MEM_TIMEOUT=4, mem_ready held at 0 in FETCH -> TRAP after the 5th FETCH cycle, mem_timeout=1 stays set, then rst clears it to 0 and returns to FETCH.
REQ-040 opcode=3Fh -> illegal_op pulses for one cycle in DECODE, then FETCH; no reg_write, mem_write or pc_write is asserted.
REQ-041 opcode=0Ch -> alu_op=11 in IMM_EX; rst asserted during IMM_EX -> IMM_WB never reached and reg_write never asserted.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared state encodings, opcodes and datapath select codes for the multicycle controller
package cpu_ctrl_pkg;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_R_EX,
    S_R_WB, S_BRANCH, S_JUMP, S_IMM_EX, S_IMM_WB, S_TRAP
  } state_t;
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_ANDI = 6'h0C, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [1:0] ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_FUNCT = 2'b10, ALU_AND = 2'b11;
  localparam logic [1:0] SRCB_REG = 2'b00, SRCB_FOUR = 2'b01, SRCB_IMM = 2'b10, SRCB_BOFF = 2'b11;
  localparam logic [1:0] PC_ALU = 2'b00, PC_ALUOUT = 2'b01, PC_JUMP = 2'b10;
  // Unsupported opcodes fall back to FETCH, which is also how illegal_op is detected
  function automatic state_t decode_next(input logic [5:0] op);
    case (op)
      OP_LW, OP_SW: return S_MEM_ADR;
      OP_RTYPE: return S_R_EX;
      OP_BEQ, OP_BNE: return S_BRANCH;
      OP_J: return S_JUMP;
      OP_ADDI, OP_ANDI: return S_IMM_EX;
      default: return S_FETCH;
    endcase
  endfunction
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts stalled memory cycles and flags when the limit is reached
module mem_wait_timer #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic waiting,
  output logic expired
);
  logic [7:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (waiting) cnt <= cnt + 8'd1;
  assign expired = cnt == 8'(LIMIT);
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: Moore control FSM for a multicycle MIPS-style datapath with memory timeout trap
module multicycle_control
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int ALUOP_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               beq_sel,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_source,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               illegal_op,
  output logic               mem_timeout,
  output logic [3:0]         state
);
  state_t cs, ns;
  logic [5:0] op_q;
  logic [1:0] aop;
  logic waiting, expired;
  assign waiting = (cs == S_FETCH || cs == S_MEM_RD || cs == S_MEM_WR) && !mem_ready;
  // Any state change restarts the count, so each wait state starts from zero
  mem_wait_timer #(.LIMIT(MEM_TIMEOUT)) u_timer (
    .clk(clk), .rst(rst), .clear(ns != cs), .waiting(waiting), .expired(expired)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) cs <= S_FETCH;
    else cs <= ns;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      op_q <= '0;
      mem_timeout <= 1'b0;
    end else begin
      if (cs == S_DECODE) op_q <= opcode;
      if (ns == S_TRAP) mem_timeout <= 1'b1;
    end
  always_comb begin
    ns = cs;
    case (cs)
      S_FETCH:   ns = mem_ready ? S_DECODE : (expired ? S_TRAP : S_FETCH);
      S_DECODE:  ns = decode_next(opcode);
      S_MEM_ADR: ns = (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:  ns = mem_ready ? S_MEM_WB : (expired ? S_TRAP : S_MEM_RD);
      S_MEM_WR:  ns = mem_ready ? S_FETCH : (expired ? S_TRAP : S_MEM_WR);
      S_R_EX:    ns = S_R_WB;
      S_IMM_EX:  ns = S_IMM_WB;
      S_TRAP:    ns = S_TRAP;
      default:   ns = S_FETCH;
    endcase
  end
  always_comb begin
    {pc_write, pc_write_cond, beq_sel, i_or_d, mem_read, mem_write, ir_write,
     mem_to_reg, reg_write, reg_dst, alu_src_a, illegal_op} = '0;
    alu_src_b = SRCB_REG;
    pc_source = PC_ALU;
    aop = ALU_ADD;
    case (cs)
      S_FETCH: begin
        mem_read = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = SRCB_BOFF;
        illegal_op = decode_next(opcode) == S_FETCH;
      end
      S_MEM_ADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        i_or_d = 1'b1;
        mem_read = 1'b1;
      end
      S_MEM_WB: begin
        mem_to_reg = 1'b1;
        reg_write = 1'b1;
      end
      S_MEM_WR: begin
        i_or_d = 1'b1;
        mem_write = 1'b1;
      end
      S_R_EX: begin
        alu_src_a = 1'b1;
        aop = ALU_FUNCT;
      end
      S_R_WB: begin
        reg_dst = 1'b1;
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        aop = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source = PC_ALUOUT;
        beq_sel = op_q == OP_BEQ;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_source = PC_JUMP;
      end
      S_IMM_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        aop = (op_q == OP_ANDI) ? ALU_AND : ALU_ADD;
      end
      S_IMM_WB: reg_write = 1'b1;
      default: ;
    endcase
  end
  assign alu_op = ALUOP_W'(aop);
  assign state = cs;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: random instruction stream against an instruction-level plan model
module tb_multicycle_control;
  localparam int T = 4;
  logic clk = 1'b0, rst = 1'b1, mem_ready = 1'b0;
  logic [5:0] opcode = '0;
  logic pc_write, pc_write_cond, beq_sel, i_or_d, mem_read, mem_write, ir_write;
  logic mem_to_reg, reg_write, reg_dst, alu_src_a, illegal_op, mem_timeout;
  logic [1:0] alu_src_b, pc_source, alu_op;
  logic [3:0] state;
  multicycle_control #(.MEM_TIMEOUT(T), .ALUOP_W(2)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .beq_sel(beq_sel),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .reg_dst(reg_dst),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
    .alu_op(alu_op), .illegal_op(illegal_op), .mem_timeout(mem_timeout), .state(state)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic pcw, pcwc, beq, iord, mrd, mwr, irw, m2r, rw, rdst, asa;
    logic [1:0] asb, pcs, aop;
    logic ill, mto;
    logic [3:0] st;
  } obs_t;
  obs_t q[$];
  int total = 0, passed = 0;
  bit to_flag = 1'b0;
  logic [5:0] lop = '0;
  logic [5:0] legal_ops [8] = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h23, 6'h2B};
  function automatic bit legal(input logic [5:0] o);
    return o inside {6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h23, 6'h2B};
  endfunction
  function automatic logic [5:0] rnd();
    return 6'($urandom);
  endfunction
  // Expected control outputs for one cycle, written straight from the per-state output table
  function automatic obs_t expect_obs(input logic [3:0] st, input logic r, input logic [5:0] dop);
    obs_t e = '0;
    e.st = st;
    e.mto = to_flag;
    case (st)
      4'd0: begin e.mrd = 1; e.asb = 2'b01; e.irw = r; e.pcw = r; end
      4'd1: begin e.asb = 2'b11; e.ill = !legal(dop); end
      4'd2: begin e.asa = 1; e.asb = 2'b10; end
      4'd3: begin e.iord = 1; e.mrd = 1; end
      4'd4: begin e.m2r = 1; e.rw = 1; end
      4'd5: begin e.iord = 1; e.mwr = 1; end
      4'd6: begin e.asa = 1; e.aop = 2'b10; end
      4'd7: begin e.rdst = 1; e.rw = 1; end
      4'd8: begin e.asa = 1; e.aop = 2'b01; e.pcwc = 1; e.pcs = 2'b01; e.beq = lop == 6'h04; end
      4'd9: begin e.pcw = 1; e.pcs = 2'b10; end
      4'd10: begin e.asa = 1; e.asb = 2'b10; e.aop = (lop == 6'h0C) ? 2'b11 : 2'b00; end
      4'd11: e.rw = 1;
      default: ;
    endcase
    return e;
  endfunction
  task automatic tick(input logic [3:0] st, input logic r, input logic [5:0] o, input bit rs);
    @(negedge clk);
    rst = rs;
    mem_ready = r;
    opcode = o;
    if (rs) begin
      to_flag = 1'b0;
      lop = '0;
    end
    q.push_back(expect_obs(st, r, o));
  endtask
  task automatic do_reset();
    tick(4'd0, 1'($urandom), rnd(), 1'b1);
  endtask
  task automatic trap_tail();
    to_flag = 1'b1;
    repeat (3) tick(4'd12, 1'($urandom), rnd(), 1'b0);
    do_reset();
  endtask
  // A wait state ends on the cycle ready arrives; after T+1 unready cycles it traps
  task automatic mem_phase(input logic [3:0] st, input int w, output bit tr);
    tr = 1'b0;
    for (int i = 0; i <= T; i++) begin
      tick(st, i == w, rnd(), 1'b0);
      if (i == w) return;
    end
    tr = 1'b1;
  endtask
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input int ai);
    logic [3:0] plan[$];
    bit tr;
    mem_phase(4'd0, fw, tr);
    if (tr) begin
      trap_tail();
      return;
    end
    tick(4'd1, 1'($urandom), op, 1'b0);
    if (!legal(op)) return;
    lop = op;
    case (op)
      6'h23: plan = {4'd2, 4'd3, 4'd4};
      6'h2B: plan = {4'd2, 4'd5};
      6'h00: plan = {4'd6, 4'd7};
      6'h04, 6'h05: plan = {4'd8};
      6'h02: plan = {4'd9};
      default: plan = {4'd10, 4'd11};
    endcase
    foreach (plan[k]) begin
      if (k == ai - 1) begin
        do_reset();
        return;
      end
      if (plan[k] == 4'd3 || plan[k] == 4'd5) begin
        mem_phase(plan[k], mw, tr);
        if (tr) begin
          trap_tail();
          return;
        end
      end else tick(plan[k], 1'($urandom), rnd(), 1'b0);
    end
  endtask
  initial forever begin
    @(negedge clk);
    #2;
    if (q.size() > 0) begin
      obs_t e, g;
      e = q.pop_front();
      g = {pc_write, pc_write_cond, beq_sel, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_write, reg_dst, alu_src_a, alu_src_b, pc_source, alu_op,
           illegal_op, mem_timeout, state};
      total++;
      if (g === e) passed++;
      else $display("FAIL obs t=%0t state got=%0d exp=%0d vec got=%h exp=%h",
                    $time, g.st, e.st, g, e);
    end
  end
  initial begin
    logic [5:0] op;
    do_reset();
    run_instr(6'h23, 0, 0, 0);
    run_instr(6'h05, 0, 0, 0);
    run_instr(6'h04, 1, 0, 0);
    run_instr(6'h2B, 0, 3, 0);
    run_instr(6'h23, 2, T, 0);
    run_instr(6'h23, 99, 0, 0);
    run_instr(6'h3F, 0, 0, 0);
    run_instr(6'h0C, 0, 0, 1);
    run_instr(6'h0C, 0, 0, 0);
    run_instr(6'h08, 0, 0, 0);
    run_instr(6'h00, 0, 0, 0);
    run_instr(6'h02, 0, 0, 0);
    run_instr(6'h2B, 0, 99, 0);
    repeat (300) begin
      op = ($urandom_range(0, 4) == 0) ? rnd() : legal_ops[$urandom_range(0, 7)];
      run_instr(op,
                ($urandom_range(0, 9) == 0) ? $urandom_range(T, T + 3) : $urandom_range(0, 3),
                ($urandom_range(0, 9) == 0) ? $urandom_range(T, T + 3) : $urandom_range(0, 3),
                ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0);
    end
    repeat (3) @(negedge clk);
    total++;
    if (q.size() == 0) passed++;
    else $display("FAIL drain left=%0d exp=0", q.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
